muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 125 ++++++++++++
 tb/tb_muldiv_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, radix-2 shift-add multiply and restoring divide, fixed WIDTH+2 latency.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ma_q, ma_d, mb_q, mb_d, result_q, result_d;
  logic na_q, na_d, nb_q, nb_d, dz_q, dz_d, ov_q, ov_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] mul_sum, r_sh;
  logic [WIDTH-1:0] r_sub, quo_s, rem_s, fix_res;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod_s;
  logic ge, sa, sb;
  assign busy   = state_q == PREP || state_q == RUN || state_q == FIX;
  assign done   = state_q == DONE;
  assign result = result_q;
  assign sa = ~(op_q[1] & op_q[0]);
  assign sb = ~op_q[1];
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, prod_q[0] ? ma_q : {WIDTH{1'b0}}};
  assign mul_nx  = {mul_sum, prod_q[WIDTH-1:1]};
  // Remainder lives in the upper half, dividend shifts out of the lower half as quotient bits shift in.
  assign r_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign ge     = r_sh >= {1'b0, mb_q};
  assign r_sub  = r_sh[WIDTH-1:0] - mb_q;
  assign div_nx = {ge ? r_sub : r_sh[WIDTH-1:0], prod_q[WIDTH-2:0], ge};
  assign prod_s = (na_q ^ nb_q) ? -prod_q : prod_q;
  assign quo_s  = (na_q ^ nb_q) ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
  assign rem_s  = na_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
  assign fix_res = !op_q[2] ? (op_q[1:0] == 2'b00 ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH])
                 : op_q[1:0] == 2'b00 ? (dz_q ? {WIDTH{1'b1}} : ov_q ? {1'b1, {(WIDTH-1){1'b0}}} : quo_s)
                 : (dz_q ? a_q : ov_q ? {WIDTH{1'b0}} : rem_s);
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    na_d     = na_q;
    nb_d     = nb_q;
    dz_d     = dz_q;
    ov_d     = ov_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start && alu_op[4:3] == 2'b11 && alu_op[2:0] != 3'b110) begin
        state_d = PREP;
        op_d    = alu_op[2:0];
        a_d     = rs1;
        b_d     = rs2;
      end
      PREP: begin
        na_d    = sa & a_q[WIDTH-1];
        nb_d    = sb & b_q[WIDTH-1];
        ma_d    = na_d ? -a_q : a_q;
        mb_d    = nb_d ? -b_q : b_q;
        dz_d    = b_q == '0;
        ov_d    = op_q[2] && !op_q[1] && a_q == {1'b1, {(WIDTH-1){1'b0}}} && &b_q;
        prod_d  = {{WIDTH{1'b0}}, op_q[2] ? ma_d : mb_d};
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        prod_d  = op_q[2] ? div_nx : mul_nx;
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(WIDTH-1) ? FIX : RUN;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (kill && busy) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      na_q     <= 1'b0;
      nb_q     <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      na_q     <= na_d;
      nb_q     <= nb_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results, latency, abort and reset checks.
module tb_muldiv_unit;
  localparam logic [4:0] MUL = 5'b11000, MULH = 5'b11001, MULHSU = 5'b11010, MULHU = 5'b11011;
  localparam logic [4:0] DIV = 5'b11100, REM = 5'b11101, REMU = 5'b11111, LUI = 5'b11110;
  logic clk, rst, start, kill, busy, done;
  logic [4:0] alu_op;
  logic [31:0] rs1, rs2, result;
  int tests, fails;
  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .rs1(rs1), .rs2(rs2),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alu_op = op; rs1 = a; rs2 = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input logic [31:0] exp, input bit poke);
    int n;
    bit all_busy;
    n = 0;
    all_busy = busy;
    while (!done && n < 60) begin
      @(negedge clk);
      if (poke) begin
        start = (n >= 3 && n <= 5); alu_op = DIV; rs1 = 32'd100; rs2 = 32'd7;
      end
      @(posedge clk);
      #1 n++;
      if (!done) all_busy &= busy;
    end
    chk({tag, "_latency"}, n, 34);
    chk({tag, "_busy_run"}, {31'd0, all_busy}, 1);
    chk({tag, "_busy_done"}, {31'd0, busy}, 0);
    chk({tag, "_result"}, result, exp);
    @(posedge clk);
    #1 chk({tag, "_done_drop"}, {31'd0, done}, 0);
  endtask
  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    start_op(op, a, b);
    wait_done(tag, exp, 1'b0);
  endtask
  initial begin
    bit seen;
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; kill = 1'b0; alu_op = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_result", result, 0);
    @(negedge clk) rst = 1'b0;
    run("mul_7_m3", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run("mulh_min", MULH, 32'h80000000, 32'h80000000, 32'h40000000);
    run("mulhu_ones", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("mulhsu_ones", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run("rem_m7_2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run("remu_big_2", REMU, 32'hFFFFFFF9, 32'd2, 32'd1);
    run("div_100_7", DIV, 32'd100, 32'd7, 32'd14);
    run("div_by0", DIV, 32'd5, 32'd0, 32'hFFFFFFFF);
    run("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    run("remu_by0", REMU, 32'h1234, 32'd0, 32'h1234);
    start_op(MUL, 32'd6, 32'd6);
    repeat (11) @(posedge clk);
    @(negedge clk) kill = 1'b1;
    @(posedge clk);
    #1 chk("kill_busy", {31'd0, busy}, 0);
    @(negedge clk) kill = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= done | busy;
    end
    chk("kill_no_done", {31'd0, seen}, 0);
    chk("kill_result_kept", result, 32'h1234);
    start_op(MUL, 32'd3, 32'd5);
    wait_done("start_while_busy", 32'd15, 1'b1);
    @(negedge clk);
    start = 1'b1; alu_op = LUI; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    seen = busy;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= done | busy;
    end
    chk("lui_ignored", {31'd0, seen}, 0);
    chk("lui_result_kept", result, 32'd15);
    start_op(MUL, 32'd9, 32'd9);
    repeat (15) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_result", result, 0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= done;
    end
    chk("midrst_no_done", {31'd0, seen}, 0);
    run("mul_3_4", MUL, 32'd3, 32'd4, 32'd12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
